mem_stage: RTL

//  MEM pipeline stage directly downstream of the EX stage. Holds the EX/MEM pipeline register.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage_align.sv | 38 +++
 rtl/mem_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: memory-op codes, FSM state codes and exception bit positions.
package mem_stage_pkg;

    localparam logic [2:0] MOP_W  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_HU = 3'b010;
    localparam logic [2:0] MOP_B  = 3'b011;
    localparam logic [2:0] MOP_BU = 3'b100;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int EXC_OVF = 0;
    localparam int EXC_MIS = 1;

    // Words need a 4-byte aligned address, halves a 2-byte aligned one; bytes never fault.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
        return ((op == MOP_W) && (lo != 2'b00)) ||
               (((op == MOP_H) || (op == MOP_HU)) && lo[0]);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_stage_if #(parameter int DW = 32);
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_align.sv
// Sub-word lane steering: byte enables and replicated store data out, extended load result in.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    addr_lo,
    input  logic [2:0]    mem_op,
    input  logic [DW-1:0] store_data,
    input  logic [DW-1:0] rdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data
);
    logic [7:0]  lb;
    logic [15:0] lh;

    always_comb begin
        lb        = rdata[{addr_lo, 3'b000} +: 8];
        lh        = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (mem_op)
            MOP_B, MOP_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (mem_op == MOP_B) ? {{24{lb[7]}}, lb} : {24'b0, lb};
            end
            MOP_H, MOP_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = (mem_op == MOP_H) ? {{16{lh[15]}}, lh} : {16'b0, lh};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory req/ack FSM, stall generation and MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_E,
    input  logic [DW-1:0]  alu_out_E,
    input  logic [DW-1:0]  store_data_E,
    input  logic [RAW-1:0] reg_src3_E,
    input  logic           reg_wr_E,
    input  logic           mem_rd_E,
    input  logic           mem_wr_E,
    input  logic [2:0]     mem_op_E,
    input  logic           overflow_E,
    input  logic           flush_E,
    output logic           stall_M,
    mem_stage_if.master    dmem,
    output logic           valid_W,
    output logic           reg_wr_W,
    output logic [RAW-1:0] dst_W,
    output logic [DW-1:0]  wdata_W,
    output logic [1:0]     exc_W
);
    logic           valid_m, rw_m, rd_m, wr_m, ovf_m;
    logic [DW-1:0]  alu_m, sd_m;
    logic [RAW-1:0] dst_m;
    logic [2:0]     op_m;
    logic [0:0]     state;

    logic          mis_m, exc_m, go, in_access;
    logic [3:0]    be_a;
    logic [DW-1:0] wdata_a, load_data;

    mem_align #(.DW(DW)) u_align (
        .addr_lo    (alu_m[1:0]),
        .mem_op     (op_m),
        .store_data (sd_m),
        .rdata      (dmem.rdata),
        .be         (be_a),
        .wdata      (wdata_a),
        .load_data  (load_data)
    );

    always_comb begin
        mis_m     = (rd_m | wr_m) & misaligned(op_m, alu_m[1:0]);
        exc_m     = ovf_m | mis_m;
        go        = valid_m & (rd_m | wr_m) & ~exc_m;
        in_access = (state == ST_ACCESS);
        // Stall covers the issue cycle in IDLE and every ACCESS cycle until ack arrives.
        stall_M   = go & ~(in_access & dmem.ack);
    end

    // EX/MEM is only reloaded at an edge with no stall, so the bus stays stable through ACCESS.
    assign dmem.req   = in_access;
    assign dmem.we    = in_access & wr_m;
    assign dmem.be    = in_access ? be_a : 4'b0000;
    assign dmem.addr  = {alu_m[DW-1:2], 2'b00};
    assign dmem.wdata = wdata_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (go) state <= ST_ACCESS;
                ST_ACCESS: if (dmem.ack) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m <= 1'b0;
            alu_m   <= '0;
            sd_m    <= '0;
            dst_m   <= '0;
            rw_m    <= 1'b0;
            rd_m    <= 1'b0;
            wr_m    <= 1'b0;
            op_m    <= MOP_W;
            ovf_m   <= 1'b0;
        end else if (!stall_M) begin
            valid_m <= valid_E & ~flush_E;
            alu_m   <= alu_out_E;
            sd_m    <= store_data_E;
            dst_m   <= reg_src3_E;
            rw_m    <= reg_wr_E;
            rd_m    <= mem_rd_E;
            wr_m    <= mem_wr_E;
            op_m    <= mem_op_E;
            ovf_m   <= overflow_E;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_W  <= 1'b0;
            reg_wr_W <= 1'b0;
            dst_W    <= '0;
            wdata_W  <= '0;
            exc_W    <= 2'b00;
        end else if (stall_M) begin
            valid_W  <= 1'b0;
            reg_wr_W <= 1'b0;
            exc_W    <= 2'b00;
        end else begin
            valid_W           <= valid_m;
            reg_wr_W          <= valid_m & rw_m & ~wr_m & ~exc_m;
            dst_W             <= dst_m;
            wdata_W           <= (rd_m & ~exc_m) ? load_data : alu_m;
            exc_W[EXC_OVF]    <= valid_m & ovf_m;
            exc_W[EXC_MIS]    <= valid_m & mis_m;
        end
    end
endmodule
